player_physics: RTL and testbench

Parametrised per-player motion and physics engine for the platformer: converts keycode bits into horizontal motion, gravity-driven jumps, wall and ground clamping, and a timed respawn after death. Sits between the keyboard decoder and the sprite renderer, ticking once per `frame_clk` edge. The game FSM gates it via `current_state_out`. It generalises the single-ball controller with signed velocity, a terminal fall speed, a ceiling, an explicit motion FSM and a respawn delay. The velocity update feeds the same-frame position update.

---
 rtl/player_physics_pkg.sv | 55 +++++
 rtl/player_physics.sv | 173 +++++++++++++++++
 tb/tb_player_physics.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/player_physics_pkg.sv
// -----------------------------------------------------------------------------
// state_definition
//   Shared definitions for the platformer: the game-level state encoding that
//   the game FSM drives onto current_state_out, the per-player motion state
//   enum, and the signed helper arithmetic used by the physics step.
//
//   All helper arithmetic works on a fixed 16-bit signed container.
//   Callers sign-extend their narrower operands into it and truncate the
//   result back. The physics module keeps its own sums at VW+3 bits, which
//   must not exceed CALC_W.
// -----------------------------------------------------------------------------
package state_definition;

  // Game-level states as driven by the game FSM
  typedef enum logic [1:0] {
    START     = 2'd0,
    PLAYING   = 2'd1,
    PAUSED    = 2'd2,
    GAME_OVER = 2'd3
  } game_state_t;

  // Per-player motion states
  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    AIRBORNE = 2'd1,
    DEAD     = 2'd2
  } phys_state_t;

  // Keycode bit positions
  localparam int KEY_LEFT     = 7;
  localparam int KEY_JUMP     = 6;
  localparam int KEY_RIGHT    = 5;
  localparam int KEY_GRAV_OFF = 1;

  localparam int CALC_W = 16;
  typedef logic signed [CALC_W-1:0] calc_t;

  // a + b, limited from above to hi (terminal fall speed)
  function automatic calc_t sat_add(input calc_t a, input calc_t b, input calc_t hi);
    calc_t s;
    s = a + b;
    if (s > hi) s = hi;
    return s;
  endfunction

  // Limit v to the closed range [lo, hi]
  function automatic calc_t clamp(input calc_t v, input calc_t lo, input calc_t hi);
    calc_t r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/player_physics.sv
// -----------------------------------------------------------------------------
// player_physics
//   Per-player motion engine. Each frame_clk edge performs one physics step.
//   The step turns the keycode into horizontal motion, runs the jump and
//   gravity model with a terminal fall speed, clamps against the side walls,
//   floor and ceiling, and hides the player for a fixed number of frames
//   after a death.
//
//   State | meaning
//   ------+--------------------------------------------------------------
//   GROUNDED | standing on the floor (Y = Y_GROUND), jump may launch
//   AIRBORNE | in flight, gravity integrates into Vy each frame
//   DEAD     | hidden at the start position, respawn counter running
//
//   Ports
//     frame_clk         in  1   physics tick, one step per rising edge
//     Reset             in  1   synchronous, active-high
//     current_state_out in  2   game state; motion only while PLAYING
//     keycode           in  8   [7]=left [6]=jump [5]=right [1]=gravity off
//     die               in  1   death request, level-sampled
//     BallX, BallY      out 10  sprite top-left position
//     BallS             out 10  sprite size (constant SIZE)
//     grounded          out 1   state is GROUNDED
//     visible           out 1   state is not DEAD
// -----------------------------------------------------------------------------
module player_physics
  import state_definition::*;
#(
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 639,
  parameter int Y_MIN          = 0,
  parameter int Y_GROUND       = 463,
  parameter int MARGIN         = 18,
  parameter int X_START        = 100,
  parameter int Y_START        = 463,
  parameter int SIZE           = 16,
  parameter int X_SPEED        = 1,
  parameter int JUMP_V         = 10,
  parameter int GRAVITY        = 1,
  parameter int VMAX_FALL      = 12,
  parameter int VW             = 8,
  parameter int RESPAWN_FRAMES = 30
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [1:0] current_state_out,
  input  logic [7:0] keycode,
  input  logic       die,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] BallS,
  output logic       grounded,
  output logic       visible
);

  localparam int AW   = VW + 3;
  localparam int CW   = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
  localparam int X_LO = X_MIN + MARGIN;
  localparam int X_HI = X_MAX - MARGIN;

  typedef logic signed [VW-1:0] vel_t;
  typedef logic signed [AW-1:0] axis_t;

  phys_state_t   state_q, state_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  vel_t          vx_q, vx_d, vy_q, vy_d;
  vel_t          vx_new, vy_new;
  logic [CW-1:0] cnt_q, cnt_d;
  axis_t         x_sum, y_sum;
  calc_t         x_cl, y_cl, grav;
  logic          key_left, key_right, key_jump, grav_off, playing;
  logic          unused_keys;

  assign key_left  = keycode[KEY_LEFT];
  assign key_right = keycode[KEY_RIGHT];
  assign key_jump  = keycode[KEY_JUMP];
  assign grav_off  = keycode[KEY_GRAV_OFF];
  assign playing   = (current_state_out == PLAYING);

  // Remaining keycode bits belong to other consumers of the keyboard decoder
  assign unused_keys = ^{keycode[4:2], keycode[0]};

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= GROUNDED;
      x_q     <= 10'(X_START);
      y_q     <= 10'(Y_START);
      vx_q    <= '0;
      vy_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    cnt_d   = cnt_q;
    vx_new  = '0;
    vy_new  = vy_q;
    x_sum   = '0;
    y_sum   = '0;
    x_cl    = '0;
    y_cl    = '0;
    grav    = grav_off ? calc_t'(0) : calc_t'(GRAVITY);

    if (die && (state_q != DEAD)) begin
      state_d = DEAD;
      x_d     = 10'(X_START);
      y_d     = 10'(Y_START);
      vx_d    = '0;
      vy_d    = '0;
      cnt_d   = CW'(RESPAWN_FRAMES - 1);
    end else if (playing) begin
      if (state_q == DEAD) begin
        // Respawn drops in at the start position and lands on the next step
        if (cnt_q == '0) state_d = AIRBORNE;
        else             cnt_d   = cnt_q - 1'b1;
      end else begin
        // Horizontal: opposing keys cancel
        if (key_left && !key_right)      vx_new = vel_t'(-X_SPEED);
        else if (key_right && !key_left) vx_new = vel_t'(X_SPEED);

        x_sum = axis_t'({1'b0, x_q}) + axis_t'(vx_new);
        x_cl  = clamp(calc_t'(x_sum), calc_t'(X_LO), calc_t'(X_HI));
        x_d   = x_cl[9:0];
        vx_d  = ((x_cl == calc_t'(X_LO)) || (x_cl == calc_t'(X_HI))) ? vel_t'(0) : vx_new;

        // Vertical: launch frame skips gravity; in flight gravity saturates
        if (state_q == GROUNDED) begin
          if (key_jump) begin
            vy_new  = vel_t'(-JUMP_V);
            state_d = AIRBORNE;
          end else begin
            vy_new  = '0;
          end
        end else begin
          vy_new = vel_t'(sat_add(calc_t'(vy_q), grav, calc_t'(VMAX_FALL)));
        end

        // Position uses this frame's velocity (semi-implicit Euler)
        y_sum = axis_t'({1'b0, y_q}) + axis_t'(vy_new);
        y_cl  = clamp(calc_t'(y_sum), calc_t'(Y_MIN), calc_t'(Y_GROUND));
        y_d   = y_cl[9:0];
        if (y_cl == calc_t'(Y_GROUND)) begin
          vy_d    = '0;
          state_d = GROUNDED;
        end else if (y_cl == calc_t'(Y_MIN)) begin
          vy_d    = '0;
          state_d = AIRBORNE;
        end else begin
          vy_d    = vy_new;
        end
      end
    end
  end

  assign BallX    = x_q;
  assign BallY    = y_q;
  assign BallS    = 10'(SIZE);
  assign grounded = (state_q == GROUNDED);
  assign visible  = (state_q != DEAD);

endmodule

// File: tb/tb_player_physics.sv
// -----------------------------------------------------------------------------
// tb_player_physics
//   Scenario bench for player_physics with default parameters. Each scenario
//   pushes the expected {X, Y, grounded, visible} for an edge onto a
//   scoreboard queue as it drives that edge. After the edge it pops the entry
//   and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_player_physics;
  import state_definition::*;

  logic       frame_clk = 1'b0;
  logic       Reset     = 1'b1;
  logic [1:0] current_state_out = PLAYING;
  logic [7:0] keycode = 8'h00;
  logic       die     = 1'b0;
  logic [9:0] BallX, BallY, BallS;
  logic       grounded, visible;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    int          idx;
    logic [21:0] exp;
  } exp_t;

  exp_t sb[$];

  localparam logic [7:0] K_NONE  = 8'h00;
  localparam logic [7:0] K_LEFT  = 8'h80;
  localparam logic [7:0] K_JUMP  = 8'h40;
  localparam logic [7:0] K_RIGHT = 8'h20;
  localparam logic [7:0] K_GOFF  = 8'h02;

  player_physics dut (
    .frame_clk        (frame_clk),
    .Reset            (Reset),
    .current_state_out(current_state_out),
    .keycode          (keycode),
    .die              (die),
    .BallX            (BallX),
    .BallY            (BallY),
    .BallS            (BallS),
    .grounded         (grounded),
    .visible          (visible)
  );

  always #5 frame_clk = ~frame_clk;

  function automatic logic [21:0] pk(input int x, input int y, input bit g, input bit v);
    return {10'(x), 10'(y), g, v};
  endfunction

  // Height after n frames of a standard jump launched from the floor:
  // Vy on frame k is k-11, so Y = 463 + n(n+1)/2 - 11n.
  function automatic int jump_y(input int n);
    return 463 + (n * (n + 1)) / 2 - 11 * n;
  endfunction

  // Drive one edge's inputs, let the edge happen, sample 1 time unit later
  task automatic apply(input logic [7:0] k, input logic [1:0] gs, input logic d, input logic r);
    Reset = r;
    keycode = k;
    current_state_out = gs;
    die = d;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    sb.push_back('{"reset_hold", 0, pk(100, 463, 1, 1)});
    apply(K_NONE, PLAYING, 1'b0, 1'b1);
    e = sb.pop_front();
    total++;
    if ({BallX, BallY, grounded, visible} !== e.exp) begin
      bad++;
      $display("FAIL %s[%0d]: got x=%0d y=%0d g=%0b v=%0b want x=%0d y=%0d g=%0b v=%0b",
               e.name, e.idx, BallX, BallY, grounded, visible, e.exp[21:12], e.exp[11:2], e.exp[1], e.exp[0]);
    end
    sb.push_back('{"reset_idle", 1, pk(100, 463, 1, 1)});
    apply(K_NONE, PLAYING, 1'b0, 1'b0);
    e = sb.pop_front();
    total++;
    if ({BallX, BallY, grounded, visible} !== e.exp) begin
      bad++;
      $display("FAIL %s[%0d]: got x=%0d y=%0d g=%0b v=%0b want x=%0d y=%0d g=%0b v=%0b",
               e.name, e.idx, BallX, BallY, grounded, visible, e.exp[21:12], e.exp[11:2], e.exp[1], e.exp[0]);
    end
    total++;
    if (BallS !== 10'd16) begin
      bad++;
      $display("FAIL size: got %0d want 16", BallS);
    end
  endtask

  // Single jump pulse, then released: full arc back to the floor
  task automatic test_jump();
    exp_t e;
    apply(K_NONE, PLAYING, 1'b0, 1'b1);
    for (int n = 1; n <= 22; n++) begin
      sb.push_back('{"jump", n, pk(100, (n >= 21) ? 463 : jump_y(n), n >= 21, 1)});
      apply((n == 1) ? K_JUMP : K_NONE, PLAYING, 1'b0, 1'b0);
      e = sb.pop_front();
      total++;
      if ({BallX, BallY, grounded, visible} !== e.exp) begin
        bad++;
        $display("FAIL %s[%0d]: got x=%0d y=%0d g=%0b v=%0b want x=%0d y=%0d g=%0b v=%0b",
                 e.name, e.idx, BallX, BallY, grounded, visible, e.exp[21:12], e.exp[11:2], e.exp[1], e.exp[0]);
      end
    end
  endtask

  // Jump held continuously: lands on frame 21, relaunches on frame 22
  task automatic test_bunny_hop();
    exp_t e;
    int   y;
    apply(K_NONE, PLAYING, 1'b0, 1'b1);
    for (int n = 1; n <= 23; n++) begin
      if (n <= 20)       y = jump_y(n);
      else if (n == 21)  y = 463;
      else               y = jump_y(n - 21);
      sb.push_back('{"bunny", n, pk(100, y, n == 21, 1)});
      apply(K_JUMP, PLAYING, 1'b0, 1'b0);
      e = sb.pop_front();
      total++;
      if ({BallX, BallY, grounded, visible} !== e.exp) begin
        bad++;
        $display("FAIL %s[%0d]: got x=%0d y=%0d g=%0b v=%0b want x=%0d y=%0d g=%0b v=%0b",
                 e.name, e.idx, BallX, BallY, grounded, visible, e.exp[21:12], e.exp[11:2], e.exp[1], e.exp[0]);
      end
    end
  endtask

  // Walk right into the wall at 621, then both keys, then step back left
  task automatic test_walls();
    exp_t        e;
    int          x;
    logic [7:0]  k;
    apply(K_NONE, PLAYING, 1'b0, 1'b1);
    for (int n = 1; n <= 530; n++) begin
      if (n <= 525) begin
        k = K_RIGHT;
        x = (100 + n > 621) ? 621 : 100 + n;
      end else if (n <= 528) begin
        k = K_LEFT | K_RIGHT;
        x = 621;
      end else begin
        k = K_LEFT;
        x = 621 - (n - 528);
      end
      sb.push_back('{"walls", n, pk(x, 463, 1, 1)});
      apply(k, PLAYING, 1'b0, 1'b0);
      e = sb.pop_front();
      total++;
      if ({BallX, BallY, grounded, visible} !== e.exp) begin
        bad++;
        $display("FAIL %s[%0d]: got x=%0d y=%0d g=%0b v=%0b want x=%0d y=%0d g=%0b v=%0b",
                 e.name, e.idx, BallX, BallY, grounded, visible, e.exp[21:12], e.exp[11:2], e.exp[1], e.exp[0]);
      end
    end
  endtask

  // Gravity off after launch: constant climb into the ceiling, then a
  // long fall from Y=0 that saturates at 12 px/frame and lands exactly.
  task automatic test_ceiling_and_fall();
    exp_t e;
    int   y;
    int   f;
    apply(K_NONE, PLAYING, 1'b0, 1'b1);
    for (int n = 1; n <= 50; n++) begin
      y = (463 - 10 * n < 0) ? 0 : 463 - 10 * n;
      sb.push_back('{"ceiling", n, pk(100, y, 0, 1)});
      apply((n == 1) ? (K_JUMP | K_GOFF) : K_GOFF, PLAYING, 1'b0, 1'b0);
      e = sb.pop_front();
      total++;
      if ({BallX, BallY, grounded, visible} !== e.exp) begin
        bad++;
        $display("FAIL %s[%0d]: got x=%0d y=%0d g=%0b v=%0b want x=%0d y=%0d g=%0b v=%0b",
                 e.name, e.idx, BallX, BallY, grounded, visible, e.exp[21:12], e.exp[11:2], e.exp[1], e.exp[0]);
      end
    end
    for (int n = 1; n <= 47; n++) begin
      f = (n <= 12) ? (n * (n + 1)) / 2 : 78 + 12 * (n - 12);
      sb.push_back('{"fall", n, pk(100, (f >= 463) ? 463 : f, f >= 463, 1)});
      apply(K_NONE, PLAYING, 1'b0, 1'b0);
      e = sb.pop_front();
      total++;
      if ({BallX, BallY, grounded, visible} !== e.exp) begin
        bad++;
        $display("FAIL %s[%0d]: got x=%0d y=%0d g=%0b v=%0b want x=%0d y=%0d g=%0b v=%0b",
                 e.name, e.idx, BallX, BallY, grounded, visible, e.exp[21:12], e.exp[11:2], e.exp[1], e.exp[0]);
      end
    end
  endtask

  // Die mid-air (die held over two edges, second is ignored), with a
  // freeze in the middle of the respawn countdown.
  task automatic test_respawn();
    exp_t       e;
    int         p;
    logic       frozen;
    apply(K_NONE, PLAYING, 1'b0, 1'b1);
    apply(K_JUMP | K_RIGHT, PLAYING, 1'b0, 1'b0);
    apply(K_RIGHT, PLAYING, 1'b0, 1'b0);
    sb.push_back('{"die", 0, pk(100, 463, 0, 0)});
    apply(K_RIGHT, PLAYING, 1'b1, 1'b0);
    e = sb.pop_front();
    total++;
    if ({BallX, BallY, grounded, visible} !== e.exp) begin
      bad++;
      $display("FAIL %s[%0d]: got x=%0d y=%0d g=%0b v=%0b want x=%0d y=%0d g=%0b v=%0b",
               e.name, e.idx, BallX, BallY, grounded, visible, e.exp[21:12], e.exp[11:2], e.exp[1], e.exp[0]);
    end
    p = 0;
    for (int i = 1; i <= 36; i++) begin
      frozen = (i >= 9) && (i <= 13);
      if (!frozen) p++;
      sb.push_back('{"respawn", i, pk(100, 463, p >= 31, p >= 30)});
      apply(K_NONE, frozen ? PAUSED : PLAYING, i == 1, 1'b0);
      e = sb.pop_front();
      total++;
      if ({BallX, BallY, grounded, visible} !== e.exp) begin
        bad++;
        $display("FAIL %s[%0d]: got x=%0d y=%0d g=%0b v=%0b want x=%0d y=%0d g=%0b v=%0b",
                 e.name, e.idx, BallX, BallY, grounded, visible, e.exp[21:12], e.exp[11:2], e.exp[1], e.exp[0]);
      end
    end
  endtask

  // Pause mid-jump with keys held: nothing moves; resuming continues the arc
  task automatic test_freeze();
    exp_t e;
    int   n;
    apply(K_NONE, PLAYING, 1'b0, 1'b1);
    n = 0;
    for (int i = 1; i <= 25; i++) begin
      if (i <= 5 || i >= 10) begin
        n++;
        sb.push_back('{"freeze", i, pk(100, (n >= 21) ? 463 : jump_y(n), n >= 21, 1)});
        apply((i == 1) ? K_JUMP : K_NONE, PLAYING, 1'b0, 1'b0);
      end else begin
        sb.push_back('{"freeze", i, pk(100, jump_y(5), 0, 1)});
        apply(K_RIGHT | K_JUMP, (i == 7) ? GAME_OVER : PAUSED, 1'b0, 1'b0);
      end
      e = sb.pop_front();
      total++;
      if ({BallX, BallY, grounded, visible} !== e.exp) begin
        bad++;
        $display("FAIL %s[%0d]: got x=%0d y=%0d g=%0b v=%0b want x=%0d y=%0d g=%0b v=%0b",
                 e.name, e.idx, BallX, BallY, grounded, visible, e.exp[21:12], e.exp[11:2], e.exp[1], e.exp[0]);
      end
    end
  endtask

  // Reset in the middle of the DEAD countdown restores a visible, grounded player
  task automatic test_reset_dead();
    exp_t e;
    apply(K_NONE, PLAYING, 1'b0, 1'b1);
    apply(K_LEFT, PLAYING, 1'b0, 1'b0);
    apply(K_NONE, PLAYING, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) apply(K_NONE, PLAYING, 1'b0, 1'b0);
    sb.push_back('{"dead_pre", 0, pk(100, 463, 0, 0)});
    e = sb.pop_front();
    total++;
    if ({BallX, BallY, grounded, visible} !== e.exp) begin
      bad++;
      $display("FAIL %s[%0d]: got x=%0d y=%0d g=%0b v=%0b want x=%0d y=%0d g=%0b v=%0b",
               e.name, e.idx, BallX, BallY, grounded, visible, e.exp[21:12], e.exp[11:2], e.exp[1], e.exp[0]);
    end
    for (int i = 1; i <= 3; i++) begin
      sb.push_back('{"dead_reset", i, pk((i == 3) ? 101 : 100, 463, 1, 1)});
      apply((i == 3) ? K_RIGHT : K_NONE, PLAYING, 1'b0, i == 1);
      e = sb.pop_front();
      total++;
      if ({BallX, BallY, grounded, visible} !== e.exp) begin
        bad++;
        $display("FAIL %s[%0d]: got x=%0d y=%0d g=%0b v=%0b want x=%0d y=%0d g=%0b v=%0b",
                 e.name, e.idx, BallX, BallY, grounded, visible, e.exp[21:12], e.exp[11:2], e.exp[1], e.exp[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_bunny_hop();
    test_walls();
    test_ceiling_and_fall();
    test_respawn();
    test_freeze();
    test_reset_dead();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
